// File: rtl/cmd_frame_pkg.sv
// Shared types for the command-frame initiator: link opcodes, request kinds,
// FSM states and default link/register widths.
package cmd_frame_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 8;
  localparam int unsigned ADDR_WIDTH_DEF = 4;

  // First byte of each frame on the link
  typedef enum logic [7:0] {
    OPC_WR      = 8'hAA,
    OPC_RD      = 8'hBB,
    OPC_ALU_OP  = 8'hCC,
    OPC_ALU_NOP = 8'hDD
  } cmd_opc_e;

  // Encoding of the REQ_CMD port
  typedef enum logic [1:0] {
    REQ_WRITE   = 2'd0,
    REQ_READ    = 2'd1,
    REQ_ALU_OP  = 2'd2,
    REQ_ALU_NOP = 2'd3
  } req_kind_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SEND     = 2'd1,
    ST_WAIT_RSP = 2'd2
  } state_e;

endpackage

// File: rtl/cmd_rsp_timeout_cnt.sv
// Response timeout counter. Counts cycles while run is high, restarts on clr
// or when run drops, and flags expire_c in the cycle it sits at TIMEOUT_CYCLES-1.
// Ports: clk, rst_n, run (counting enable), clr (restart), expire_c (comb flag).
module cmd_rsp_timeout_cnt #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clr,
  output logic expire_c
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;

  assign expire_c = run && !clr && (cnt_q == CNT_LAST);

  // Counter restarts whenever we leave the wait window or a byte arrives
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (!run || clr || expire_c) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/cmd_frame_master.sv
// Command initiator: serialises one register/ALU request into a 2-4 byte
// frame toward the UART transmitter and assembles the 0-2 byte response.
// Ports: CLK/rst_n; REQ_* request handshake and fields; TX_P_DATA/TX_D_VLD/
// TX_BUSY transmit byte stream; RX_P_DATA/RX_D_VLD received bytes;
// RSP_DATA/RSP_VLD assembled response; RSP_TIMEOUT timeout pulse.
// Build option: CMD_FRAME_TIMEOUT_EN enables the response timeout; without it
// the block waits indefinitely and RSP_TIMEOUT stays 0.
module cmd_frame_master
  import cmd_frame_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH     = ADDR_WIDTH_DEF,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                    CLK,
  input  logic                    rst_n,
  input  logic                    REQ_VLD,
  output logic                    REQ_RDY,
  input  logic [1:0]              REQ_CMD,
  input  logic [ADDR_WIDTH-1:0]   REQ_ADDR,
  input  logic [DATA_WIDTH-1:0]   REQ_WR_DATA,
  input  logic [DATA_WIDTH-1:0]   REQ_OP_A,
  input  logic [DATA_WIDTH-1:0]   REQ_OP_B,
  input  logic [3:0]              REQ_ALU_FUN,
  output logic [DATA_WIDTH-1:0]   TX_P_DATA,
  output logic                    TX_D_VLD,
  input  logic                    TX_BUSY,
  input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
  input  logic                    RX_D_VLD,
  output logic [2*DATA_WIDTH-1:0] RSP_DATA,
  output logic                    RSP_VLD,
  output logic                    RSP_TIMEOUT
);

  localparam int unsigned RSP_WIDTH = 2 * DATA_WIDTH;

  state_e                 state_q, state_d;
  logic [DATA_WIDTH-1:0]  frame_q [3];
  logic [DATA_WIDTH-1:0]  frame_d [3];
  logic [1:0]             rem_q, rem_d;     // bytes still queued behind TX_P_DATA
  logic [1:0]             exp_q, exp_d;     // expected response byte count
  logic                   got_q, got_d;     // first response byte already taken
  logic [DATA_WIDTH-1:0]  tx_data_q, tx_data_d;
  logic                   tx_vld_q, tx_vld_d;
  logic [RSP_WIDTH-1:0]   rsp_data_q, rsp_data_d;
  logic                   rsp_vld_q, rsp_vld_d;
  logic                   rsp_to_q, rsp_to_d;
  logic                   tx_fire_c;
  logic                   wait_c;
  logic                   expire_c;

  assign tx_fire_c = tx_vld_q && !TX_BUSY;
  assign wait_c    = (state_q == ST_WAIT_RSP);

`ifdef CMD_FRAME_TIMEOUT_EN
  cmd_rsp_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rsp_timeout_cnt (
    .clk      (CLK),
    .rst_n    (rst_n),
    .run      (wait_c),
    .clr      (RX_D_VLD),
    .expire_c (expire_c)
  );
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT_CYCLES);
  assign expire_c       = 1'b0;
`endif

  assign REQ_RDY     = (state_q == ST_IDLE);
  assign TX_P_DATA   = tx_data_q;
  assign TX_D_VLD    = tx_vld_q;
  assign RSP_DATA    = rsp_data_q;
  assign RSP_VLD     = rsp_vld_q;
  assign RSP_TIMEOUT = rsp_to_q;

  // State and datapath registers
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      for (int i = 0; i < 3; i++) frame_q[i] <= '0;
      rem_q      <= '0;
      exp_q      <= '0;
      got_q      <= 1'b0;
      tx_data_q  <= '0;
      tx_vld_q   <= 1'b0;
      rsp_data_q <= '0;
      rsp_vld_q  <= 1'b0;
      rsp_to_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      frame_q    <= frame_d;
      rem_q      <= rem_d;
      exp_q      <= exp_d;
      got_q      <= got_d;
      tx_data_q  <= tx_data_d;
      tx_vld_q   <= tx_vld_d;
      rsp_data_q <= rsp_data_d;
      rsp_vld_q  <= rsp_vld_d;
      rsp_to_q   <= rsp_to_d;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    rem_d      = rem_q;
    exp_d      = exp_q;
    got_d      = got_q;
    tx_data_d  = tx_data_q;
    tx_vld_d   = tx_vld_q;
    rsp_data_d = rsp_data_q;
    rsp_vld_d  = 1'b0;
    rsp_to_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (REQ_VLD) begin
          state_d  = ST_SEND;
          tx_vld_d = 1'b1;
          got_d    = 1'b0;
          // Opcode goes straight to TX; the rest is queued in the frame buffer
          unique case (req_kind_e'(REQ_CMD))
            REQ_WRITE: begin
              tx_data_d  = DATA_WIDTH'(OPC_WR);
              frame_d[0] = DATA_WIDTH'(REQ_ADDR);
              frame_d[1] = REQ_WR_DATA;
              rem_d      = 2'd2;
              exp_d      = 2'd0;
            end
            REQ_READ: begin
              tx_data_d  = DATA_WIDTH'(OPC_RD);
              frame_d[0] = DATA_WIDTH'(REQ_ADDR);
              rem_d      = 2'd1;
              exp_d      = 2'd1;
            end
            REQ_ALU_OP: begin
              tx_data_d  = DATA_WIDTH'(OPC_ALU_OP);
              frame_d[0] = REQ_OP_A;
              frame_d[1] = REQ_OP_B;
              frame_d[2] = DATA_WIDTH'(REQ_ALU_FUN);
              rem_d      = 2'd3;
              exp_d      = 2'd2;
            end
            REQ_ALU_NOP: begin
              tx_data_d  = DATA_WIDTH'(OPC_ALU_NOP);
              frame_d[0] = DATA_WIDTH'(REQ_ALU_FUN);
              rem_d      = 2'd1;
              exp_d      = 2'd2;
            end
          endcase
        end
      end

      ST_SEND: begin
        if (tx_fire_c) begin
          if (rem_q == 2'd0) begin
            tx_vld_d = 1'b0;
            if (exp_q == 2'd0) begin
              // Write has no response bytes: signal completion with zero data
              rsp_vld_d  = 1'b1;
              rsp_data_d = '0;
              state_d    = ST_IDLE;
            end else begin
              state_d = ST_WAIT_RSP;
            end
          end else begin
            tx_data_d  = frame_q[0];
            frame_d[0] = frame_q[1];
            frame_d[1] = frame_q[2];
            rem_d      = rem_q - 2'd1;
          end
        end
      end

      ST_WAIT_RSP: begin
        if (RX_D_VLD) begin
          if (!got_q) begin
            rsp_data_d = RSP_WIDTH'(RX_P_DATA);
            if (exp_q == 2'd1) begin
              rsp_vld_d = 1'b1;
              state_d   = ST_IDLE;
            end else begin
              got_d = 1'b1;
            end
          end else begin
            rsp_data_d[RSP_WIDTH-1:DATA_WIDTH] = RX_P_DATA;
            rsp_vld_d = 1'b1;
            state_d   = ST_IDLE;
          end
        end else if (expire_c) begin
          rsp_to_d = 1'b1;
          state_d  = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cmd_frame_master.sv
// Randomised self-checking bench for cmd_frame_master with a frame/response
// reference model. Timeout scenario is exercised when CMD_FRAME_TIMEOUT_EN is set.
module tb_cmd_frame_master;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 4;
  localparam int unsigned TO = 16;

  logic          CLK = 1'b0;
  logic          rst_n;
  logic          REQ_VLD;
  logic          REQ_RDY;
  logic [1:0]    REQ_CMD;
  logic [AW-1:0] REQ_ADDR;
  logic [DW-1:0] REQ_WR_DATA, REQ_OP_A, REQ_OP_B;
  logic [3:0]    REQ_ALU_FUN;
  logic [DW-1:0] TX_P_DATA;
  logic          TX_D_VLD;
  logic          TX_BUSY;
  logic [DW-1:0] RX_P_DATA;
  logic          RX_D_VLD;
  logic [2*DW-1:0] RSP_DATA;
  logic          RSP_VLD;
  logic          RSP_TIMEOUT;

  always #5 CLK = ~CLK;

  cmd_frame_master #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .CLK(CLK), .rst_n(rst_n),
    .REQ_VLD(REQ_VLD), .REQ_RDY(REQ_RDY), .REQ_CMD(REQ_CMD), .REQ_ADDR(REQ_ADDR),
    .REQ_WR_DATA(REQ_WR_DATA), .REQ_OP_A(REQ_OP_A), .REQ_OP_B(REQ_OP_B),
    .REQ_ALU_FUN(REQ_ALU_FUN),
    .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .TX_BUSY(TX_BUSY),
    .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .RSP_DATA(RSP_DATA), .RSP_VLD(RSP_VLD), .RSP_TIMEOUT(RSP_TIMEOUT)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Model state: expected frame, expected response count, last response value
  logic [7:0]  efr [4];
  int          elen;
  int          erx;
  logic [15:0] last_rsp;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic scramble_req();
    REQ_CMD     = 2'($urandom);
    REQ_ADDR    = 4'($urandom);
    REQ_WR_DATA = 8'($urandom);
    REQ_OP_A    = 8'($urandom);
    REQ_OP_B    = 8'($urandom);
    REQ_ALU_FUN = 4'($urandom);
  endtask

  // Entered and left just after a falling edge
  task automatic send_frame(input int kind, input logic [3:0] addr, input logic [7:0] wd,
                            input logic [7:0] a, input logic [7:0] b, input logic [3:0] fun,
                            input int stall_min, input int stall_max, input bit inject);
    int s;
    case (kind)
      0: begin efr = '{8'hAA, {4'h0, addr}, wd, 8'h00};       elen = 3; erx = 0; end
      1: begin efr = '{8'hBB, {4'h0, addr}, 8'h00, 8'h00};    elen = 2; erx = 1; end
      2: begin efr = '{8'hCC, a, b, {4'h0, fun}};             elen = 4; erx = 2; end
      default: begin efr = '{8'hDD, {4'h0, fun}, 8'h00, 8'h00}; elen = 2; erx = 2; end
    endcase
    chk("rdy_before_req", 32'(REQ_RDY), 32'd1);
    REQ_VLD = 1'b1; REQ_CMD = 2'(kind); REQ_ADDR = addr; REQ_WR_DATA = wd;
    REQ_OP_A = a; REQ_OP_B = b; REQ_ALU_FUN = fun;
    @(negedge CLK);
    for (int i = 0; i < elen; i++) begin
      s = int'($urandom_range(stall_max, stall_min));
      for (int j = 0; j <= s; j++) begin
        chk("tx_vld", 32'(TX_D_VLD), 32'd1);
        chk("tx_byte", 32'(TX_P_DATA), 32'(efr[i]));
        chk("rdy_busy", 32'(REQ_RDY), 32'd0);
        TX_BUSY   = (j < s);
        REQ_VLD   = 1'($urandom);
        scramble_req();
        RX_D_VLD  = inject && 1'($urandom);
        RX_P_DATA = 8'($urandom);
        @(negedge CLK);
      end
    end
    REQ_VLD  = 1'b0;
    RX_D_VLD = 1'b0;
    TX_BUSY  = 1'b0;
    chk("tx_vld_done", 32'(TX_D_VLD), 32'd0);
  endtask

  task automatic finish_rsp(input logic [7:0] r0, input logic [7:0] r1, input int gap_max);
    int g;
    logic [15:0] exp_rsp;
    if (erx == 0) begin
      chk("wr_rsp_vld", 32'(RSP_VLD), 32'd1);
      chk("wr_rsp_data", 32'(RSP_DATA), 32'd0);
      chk("wr_rdy", 32'(REQ_RDY), 32'd1);
      last_rsp = 16'h0;
    end else begin
      chk("wait_rdy", 32'(REQ_RDY), 32'd0);
      for (int k = 0; k < erx; k++) begin
        g = int'($urandom_range(gap_max, 0));
        for (int j = 0; j < g; j++) begin
          chk("rsp_early", 32'(RSP_VLD), 32'd0);
          @(negedge CLK);
        end
        RX_D_VLD  = 1'b1;
        RX_P_DATA = (k == 0) ? r0 : r1;
        @(negedge CLK);
        RX_D_VLD  = 1'b0;
      end
      exp_rsp = (erx == 1) ? {8'h00, r0} : {r1, r0};
      chk("rsp_vld", 32'(RSP_VLD), 32'd1);
      chk("rsp_data", 32'(RSP_DATA), 32'(exp_rsp));
      chk("rsp_rdy", 32'(REQ_RDY), 32'd1);
      last_rsp = exp_rsp;
    end
    @(negedge CLK);
    chk("rsp_pulse_end", 32'(RSP_VLD), 32'd0);
    chk("rsp_hold", 32'(RSP_DATA), 32'(last_rsp));
    chk("rsp_no_to", 32'(RSP_TIMEOUT), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; REQ_VLD = 1'b0; TX_BUSY = 1'b0; RX_D_VLD = 1'b0; RX_P_DATA = '0;
    scramble_req();
    last_rsp = 16'h0;
    repeat (2) @(negedge CLK);
    chk("rst_rdy", 32'(REQ_RDY), 32'd1);
    chk("rst_tx_vld", 32'(TX_D_VLD), 32'd0);
    chk("rst_tx_data", 32'(TX_P_DATA), 32'd0);
    chk("rst_rsp_data", 32'(RSP_DATA), 32'd0);
    chk("rst_rsp_vld", 32'(RSP_VLD), 32'd0);
    chk("rst_rsp_to", 32'(RSP_TIMEOUT), 32'd0);
    rst_n = 1'b1;
    @(negedge CLK);

    // Directed scenarios
    send_frame(0, 4'h5, 8'h3C, 8'h00, 8'h00, 4'h0, 0, 0, 1'b0);
    finish_rsp(8'h00, 8'h00, 0);
    send_frame(1, 4'h2, 8'h00, 8'h00, 8'h00, 4'h0, 10, 10, 1'b0);
    finish_rsp(8'h7E, 8'h00, 3);
    send_frame(2, 4'h0, 8'h00, 8'h12, 8'h34, 4'h0, 0, 0, 1'b0);
    finish_rsp(8'h46, 8'h00, 2);
    send_frame(3, 4'h0, 8'h00, 8'h00, 8'h00, 4'h2, 0, 2, 1'b1);
    finish_rsp(8'h10, 8'h02, 2);

    // Randomised transactions
    for (int t = 0; t < 40; t++) begin
      send_frame(int'($urandom_range(3, 0)), 4'($urandom), 8'($urandom), 8'($urandom),
                 8'($urandom), 4'($urandom), 0, 3, 1'($urandom));
      finish_rsp(8'($urandom), 8'($urandom), 5);
    end

    // Asynchronous reset while the second byte of a write is on the link
    chk("rdy_pre_abort", 32'(REQ_RDY), 32'd1);
    REQ_VLD = 1'b1; REQ_CMD = 2'd0; REQ_ADDR = 4'h9; REQ_WR_DATA = 8'hA5;
    @(negedge CLK);
    REQ_VLD = 1'b0;
    chk("abort_b0", 32'(TX_P_DATA), 32'hAA);
    @(negedge CLK);
    chk("abort_b1", 32'(TX_P_DATA), 32'h09);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_rdy", 32'(REQ_RDY), 32'd1);
    chk("arst_tx_vld", 32'(TX_D_VLD), 32'd0);
    chk("arst_tx_data", 32'(TX_P_DATA), 32'd0);
    chk("arst_rsp_data", 32'(RSP_DATA), 32'd0);
    chk("arst_rsp_vld", 32'(RSP_VLD), 32'd0);
    chk("arst_rsp_to", 32'(RSP_TIMEOUT), 32'd0);
    last_rsp = 16'h0;
    @(negedge CLK);
    rst_n = 1'b1;
    @(negedge CLK);
    chk("post_rst_no_rsp", 32'(RSP_VLD), 32'd0);
    send_frame(0, 4'hC, 8'h5A, 8'h00, 8'h00, 4'h0, 0, 1, 1'b0);
    finish_rsp(8'h00, 8'h00, 0);

`ifdef CMD_FRAME_TIMEOUT_EN
    begin
      int w;
      send_frame(1, 4'h3, 8'h00, 8'h00, 8'h00, 4'h0, 0, 0, 1'b0);
      w = 0;
      while (!RSP_TIMEOUT && w < 100) begin
        chk("to_no_vld", 32'(RSP_VLD), 32'd0);
        @(negedge CLK);
        w++;
      end
      chk("to_latency", 32'(w), 32'(TO));
      chk("to_pulse", 32'(RSP_TIMEOUT), 32'd1);
      chk("to_vld_low", 32'(RSP_VLD), 32'd0);
      chk("to_data_kept", 32'(RSP_DATA), 32'(last_rsp));
      @(negedge CLK);
      chk("to_pulse_end", 32'(RSP_TIMEOUT), 32'd0);
      chk("to_rdy", 32'(REQ_RDY), 32'd1);
      send_frame(3, 4'h0, 8'h00, 8'h00, 8'h00, 4'h7, 0, 1, 1'b0);
      finish_rsp(8'h81, 8'h18, 4);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cmd_frame_master.md
# cmd_frame_master

- Command initiator for the UART-framed register/ALU command protocol.
- Accepts one high-level request (register write, register read, ALU operation with operands, ALU operation without operands) and serialises it into the command byte frame toward the UART transmitter.
- Collects the response bytes returned on the UART receiver path and presents the assembled result as a single response pulse.
- Sits on the host/test side of a link, opposite the system controller.

## Interface
Parameters:
- DATA_WIDTH, 8, byte width of the link and of the register data
- ADDR_WIDTH, 4, register-file address width; zero-extended to DATA_WIDTH on the link
- TIMEOUT_CYCLES, 1024, response timeout in CLK cycles; only used when the timeout feature is compiled in

Ports (one clock; reset is asynchronous and active-low):
- CLK  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- REQ_VLD  in  1  request valid
- REQ_RDY  out  1  idle; the request is accepted when REQ_VLD && REQ_RDY
- REQ_CMD  in  2  request kind: 0 = write, 1 = read, 2 = ALU with operands, 3 = ALU without operands
- REQ_ADDR  in  ADDR_WIDTH  register address
- REQ_WR_DATA  in  DATA_WIDTH  write data
- REQ_OP_A, REQ_OP_B  in  DATA_WIDTH  ALU operands
- REQ_ALU_FUN  in  4  ALU function code
- TX_P_DATA  out  DATA_WIDTH  byte to the transmitter
- TX_D_VLD  out  1  byte valid
- TX_BUSY  in  1  transmitter busy; a byte transfers in any cycle with TX_D_VLD && !TX_BUSY
- RX_P_DATA  in  DATA_WIDTH  received byte
- RX_D_VLD  in  1  received byte valid, one-cycle pulse per byte
- RSP_DATA  out  2*DATA_WIDTH  assembled response
- RSP_VLD  out  1  one-cycle response pulse
- RSP_TIMEOUT  out  1  one-cycle timeout pulse

## Operation
Frames, sent first byte first:
- write: 0xAA, addr, data
- read: 0xBB, addr
- ALU with operands: 0xCC, OP_A, OP_B, {0000, fun}
- ALU without operands: 0xDD, {0000, fun}
- addr = {0, REQ_ADDR}

Behaviour on acceptance:
- All request fields are captured into a frame buffer plus a length counter (2–4 bytes).
- The expected response byte count is latched: write 0, read 1, ALU 2.

State machine:
- IDLE → SEND on acceptance.
- SEND → IDLE (write) or WAIT_RSP (read/ALU) on acceptance of the final byte.
- WAIT_RSP → IDLE when the last expected RX byte is received, or on timeout.

Response assembly:
- read: RSP_DATA = {0, byte}.
- ALU: first RX byte → RSP_DATA[DATA_WIDTH-1:0], second → upper half (LSB first).
- write: RSP_VLD pulses with RSP_DATA = 0 as a completion indication.

Boundary conditions:
- RX_D_VLD in IDLE or SEND (including the cycle of the final TX acceptance) is discarded and does not count toward the response.
- TX_D_VLD is held with TX_P_DATA stable while TX_BUSY = 1; there is no bound on stall length.
- REQ_VLD while REQ_RDY = 0 is ignored; request inputs are don't-care outside the acceptance cycle.
- Reset asserted mid-frame or mid-wait aborts the transaction immediately; no partial response is emitted.
- RSP_DATA holds its value until the next response or reset.

Reset values:
- REQ_RDY = 1.
- TX_D_VLD, TX_P_DATA, RSP_DATA, RSP_VLD and RSP_TIMEOUT = 0.
- State = IDLE.

## Timing
- Acceptance in cycle A: first byte on TX_P_DATA with TX_D_VLD = 1 in cycle A+1; REQ_RDY = 0 from A+1.
- Byte accepted in cycle k: next byte is presented in cycle k+1, so back-to-back transfers are possible.
- Final byte accepted in cycle N:
  - write: RSP_VLD = 1 and REQ_RDY = 1 in N+1.
  - read/ALU: WAIT_RSP from N+1.
- Last expected RX byte sampled in cycle M: RSP_VLD = 1 with final RSP_DATA in M+1; REQ_RDY = 1 in M+1.
- All outputs are registered except REQ_RDY, which is decoded from state.

## Configuration
CMD_FRAME_TIMEOUT_EN:
- Defined:
  - A cycle counter runs in WAIT_RSP and clears on each accepted RX byte.
  - If it reaches TIMEOUT_CYCLES−1 without a byte, RSP_TIMEOUT pulses for one cycle, RSP_VLD stays 0, and the block returns to IDLE.
  - RSP_DATA keeps any partial byte already captured.
- Undefined:
  - WAIT_RSP waits indefinitely.
  - RSP_TIMEOUT is tied to 0; the port list is unchanged.

## Structure
Shared package cmd_frame_pkg holds:
- the command opcode enum (0xAA, 0xBB, 0xCC, 0xDD);
- the request-kind enum;
- the state enum;
- the DATA_WIDTH/ADDR_WIDTH defaults.

Sub-module: one natural sub-module, cmd_rsp_timeout_cnt (load/clear/expire counter), instantiated only under CMD_FRAME_TIMEOUT_EN.

## Test plan
- Write, addr 5, data 0x3C, TX_BUSY = 0: TX bytes AA, 05, 3C on consecutive cycles; RSP_VLD one cycle later with RSP_DATA 0.
- Read, addr 2, TX_BUSY high for 10 cycles after each byte: AA-style stall holds data stable; bytes BB, 02; RX byte 0x7E → RSP_DATA 0x007E, RSP_VLD once.
- ALU with operands A = 0x12, B = 0x34, fun 0: TX bytes CC, 12, 34, 00; RX 0x46 then 0x00 → RSP_DATA 0x0046.
- ALU without operands, fun 2: TX bytes DD, 02; an RX byte 0x55 injected during SEND is ignored; RX 0x10, 0x02 → RSP_DATA 0x0210.
- Timeout (macro on, TIMEOUT_CYCLES = 16): read with no RX → RSP_TIMEOUT pulse 16 cycles into WAIT_RSP, RSP_VLD never set, REQ_RDY = 1 next cycle.
- rst_n pulsed during the second byte of a write: all outputs return to reset values asynchronously; the next write completes normally.
